// File: rtl/fetch_stage_if.sv
// IF-side bus of the fetch stage: hazard/redirect inputs, instruction-memory port
// and the IF/ID register outputs consumed by the decode stage.
interface fetch_stage_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] id_instr;
  logic [3:0]         OpCode;
  logic [2:0]         Function;
  logic [PC_W-1:0]    id_pc_plus1;
  logic               id_valid;
  logic               halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, id_instr, OpCode, Function, id_pc_plus1, id_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, id_instr, OpCode, Function, id_pc_plus1, id_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with stall, redirect/flush and HALT freeze.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stalls,
`endif
  fetch_stage_if.master bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_plus1_q, id_pc_plus1_d;
  logic               id_valid_q, id_valid_d;
  logic               halted_q, halted_d;
  logic               load_en;
  logic               stall_cnt_en;
  logic [PC_W-1:0]    pc_inc;
  logic [3:0]         fetch_op;

  assign pc_inc   = pc_q + PC_W'(1);
  assign fetch_op = bus.imem_rdata[INSTR_W-1 -: 4];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus1_d = id_pc_plus1_q;
    id_valid_d    = id_valid_q;
    halted_d      = halted_q;
    load_en       = 1'b0;
    stall_cnt_en  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        id_instr_d    = '0;
        id_pc_plus1_d = '0;
        id_valid_d    = 1'b0;
        state_d       = ST_RUN;
      end
      ST_RUN, ST_HALT: begin
        if (bus.redirect) begin
          // Redirect wins over stall and cancels a HALT fetched down a wrong path.
          pc_d          = bus.redirect_pc;
          id_instr_d    = '0;
          id_pc_plus1_d = '0;
          id_valid_d    = 1'b0;
          halted_d      = 1'b0;
          state_d       = ST_RUN;
        end else if (bus.stall) begin
          stall_cnt_en = 1'b1;
        end else if (state_q == ST_RUN) begin
          load_en       = 1'b1;
          id_instr_d    = bus.imem_rdata;
          id_pc_plus1_d = pc_inc;
          id_valid_d    = 1'b1;
          if (fetch_op == HALT_OP) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end else begin
          // Halted and not stalled: feed bubbles so the HALT word is seen once.
          id_instr_d    = '0;
          id_pc_plus1_d = '0;
          id_valid_d    = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc_plus1_q <= '0;
      id_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      id_valid_q    <= id_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.OpCode      = id_instr_q[INSTR_W-1 -: 4];
  assign bus.Function    = id_instr_q[2:0];
  assign bus.id_pc_plus1 = id_pc_plus1_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (load_en && (perf_fetched_q != 32'hFFFF_FFFF))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (stall_cnt_en && (perf_stalls_q != 32'hFFFF_FFFF))
      perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`else
  logic unused_perf;
  assign unused_perf = load_en ^ stall_cnt_en;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, stall, redirect, HALT, wrap, reset.
module tb_fetch_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [15:0] mem [0:255];

  fetch_stage_if #(.PC_W(8), .INSTR_W(16)) fif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
`endif
    .bus          (fif.master)
  );

  assign fif.imem_rdata = mem[fif.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic step(input string what);
    @(posedge clk);
    @(negedge clk);
    $display("[TB] %-12s addr=%02h instr=%04h pc1=%02h v=%0b h=%0b", what,
             fif.imem_addr, fif.id_instr, fif.id_pc_plus1, fif.id_valid, fif.halted);
  endtask

  task automatic expect_id(input string tag, input logic [15:0] instr, input logic [7:0] pc1,
                           input logic v, input logic [7:0] addr);
    check_eq({tag, ".instr"}, 32'(fif.id_instr), 32'(instr));
    check_eq({tag, ".pc1"},   32'(fif.id_pc_plus1), 32'(pc1));
    check_eq({tag, ".valid"}, 32'(fif.id_valid), 32'(v));
    check_eq({tag, ".addr"},  32'(fif.imem_addr), 32'(addr));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1001; mem[8'h01] = 16'h2002; mem[8'h02] = 16'h3003;
    mem[8'h03] = 16'h4004; mem[8'h04] = 16'h5005; mem[8'h05] = 16'hF000;
    mem[8'h06] = 16'h6006; mem[8'h10] = 16'h9012; mem[8'h40] = 16'h7047;
    mem[8'hFF] = 16'hA0FF;

    rst_n = 1'b0;
    fif.stall = 1'b0;
    fif.redirect = 1'b0;
    fif.redirect_pc = 8'h00;
    step("reset");
    step("reset");
    expect_id("rst", 16'h0000, 8'h00, 1'b0, 8'h00);
    check_eq("rst.halted", 32'(fif.halted), 32'd0);

    rst_n = 1'b1;
    step("boot");
    expect_id("boot", 16'h0000, 8'h00, 1'b0, 8'h00);
    step("fetch0");
    expect_id("f0", 16'h1001, 8'h01, 1'b1, 8'h01);
    check_eq("f0.op", 32'(fif.OpCode), 32'd1);
    check_eq("f0.fn", 32'(fif.Function), 32'd1);
    step("fetch1");
    expect_id("f1", 16'h2002, 8'h02, 1'b1, 8'h02);
    check_eq("f1.op", 32'(fif.OpCode), 32'd2);
    check_eq("f1.fn", 32'(fif.Function), 32'd2);

    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      expect_id("stall", 16'h2002, 8'h02, 1'b1, 8'h02);
    end
    fif.stall = 1'b0;
    step("fetch2");
    expect_id("f2", 16'h3003, 8'h03, 1'b1, 8'h03);
    check_eq("f2.op", 32'(fif.OpCode), 32'd3);
    check_eq("f2.fn", 32'(fif.Function), 32'd3);

    fif.stall = 1'b1;
    fif.redirect = 1'b1;
    fif.redirect_pc = 8'h40;
    step("redir+stall");
    expect_id("rds", 16'h0000, 8'h00, 1'b0, 8'h40);
    check_eq("rds.op", 32'(fif.OpCode), 32'd0);
    fif.stall = 1'b0;
    fif.redirect = 1'b0;
    step("fetch40");
    expect_id("f40", 16'h7047, 8'h41, 1'b1, 8'h41);

    fif.redirect = 1'b1;
    fif.redirect_pc = 8'h04;
    step("redir4");
    expect_id("rd4", 16'h0000, 8'h00, 1'b0, 8'h04);
    fif.redirect = 1'b0;
    step("fetch4");
    expect_id("f4", 16'h5005, 8'h05, 1'b1, 8'h05);
    step("fetchHALT");
    expect_id("fh", 16'hF000, 8'h06, 1'b1, 8'h05);
    check_eq("fh.op", 32'(fif.OpCode), 32'hF);
    step("halted");
    expect_id("h1", 16'h0000, 8'h00, 1'b0, 8'h05);
    check_eq("h1.halted", 32'(fif.halted), 32'd1);
    step("halted");
    expect_id("h2", 16'h0000, 8'h00, 1'b0, 8'h05);
    check_eq("h2.halted", 32'(fif.halted), 32'd1);

    fif.redirect = 1'b1;
    fif.redirect_pc = 8'h10;
    step("unhalt");
    expect_id("uh", 16'h0000, 8'h00, 1'b0, 8'h10);
    check_eq("uh.halted", 32'(fif.halted), 32'd0);
    fif.redirect = 1'b0;
    step("fetch10");
    expect_id("f10", 16'h9012, 8'h11, 1'b1, 8'h11);

    fif.redirect = 1'b1;
    fif.redirect_pc = 8'hFF;
    step("redirFF");
    expect_id("rdff", 16'h0000, 8'h00, 1'b0, 8'hFF);
    fif.redirect = 1'b0;
    step("fetchFF");
    expect_id("wrap", 16'hA0FF, 8'h00, 1'b1, 8'h00);
    step("fetch0b");
    expect_id("f0b", 16'h1001, 8'h01, 1'b1, 8'h01);

    rst_n = 1'b0;
    step("midreset");
    expect_id("mrst", 16'h0000, 8'h00, 1'b0, 8'h00);
    rst_n = 1'b1;
    step("boot");
    expect_id("mboot", 16'h0000, 8'h00, 1'b0, 8'h00);
    step("fetch0c");
    expect_id("f0c", 16'h1001, 8'h01, 1'b1, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
